// File: rtl/stream_unpacker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : stream_unpacker                                               |
// | Brief   : Width-downconverting unpacker with valid/ready on both sides. |
// |           One IN_WIDTH beat is emitted as up to NUM_WORDS OUT_WIDTH     |
// |           words, with partial-beat counts, selectable word order and    |
// |           end-of-stream marking. Sustains one word per cycle across     |
// |           beat boundaries.                                              |
// | Options : define STREAM_UNPACKER_STATS_EN to add the words_out and      |
// |           streams_done statistics counters.                             |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module stream_unpacker #(
  parameter int IN_WIDTH  = 128,  // must be an integer multiple of OUT_WIDTH
  parameter int OUT_WIDTH = 32,
  parameter int MSB_FIRST = 0,
  localparam int NUM_WORDS = IN_WIDTH / OUT_WIDTH,
  localparam int CNT_W     = $clog2(NUM_WORDS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic [CNT_W-1:0]     s_count,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last
`ifdef STREAM_UNPACKER_STATS_EN
  ,
  output logic [31:0]          words_out,
  output logic [15:0]          streams_done
`endif
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [IN_WIDTH-1:0] sh;        // beat being drained, next word at the output end
  logic [IN_WIDTH-1:0] sh_drain;  // sh advanced by one word
  logic [CNT_W-1:0]    rem;       // words still to emit from sh
  logic [CNT_W-1:0]    eff_cnt;   // s_count with 0 and out-of-range mapped to a full beat
  logic                lst;       // current beat closes a stream
  logic                in_fire;
  logic                out_fire;

  assign eff_cnt  = ((s_count == '0) || (s_count > FULL_CNT)) ? FULL_CNT : s_count;

  // Accept a new beat when empty, or when the final word leaves this cycle,
  // so back-to-back beats produce no output bubble.
  assign s_ready  = (rem == '0) | ((rem == ONE_CNT) & m_ready);
  assign m_valid  = (rem != '0);
  assign m_last   = lst & (rem == ONE_CNT);
  assign in_fire  = s_valid & s_ready;
  assign out_fire = m_valid & m_ready;

  // Word selection and advance depend only on elaboration-time geometry.
  generate
    if (NUM_WORDS == 1) begin : g_single
      assign sh_drain = '0;
      assign m_data   = sh[OUT_WIDTH-1:0];
    end else if (MSB_FIRST != 0) begin : g_msb_first
      // Top word first; partial beats therefore use the top s_count words.
      assign sh_drain = {sh[IN_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
      assign m_data   = sh[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb_first
      assign sh_drain = {{OUT_WIDTH{1'b0}}, sh[IN_WIDTH-1:OUT_WIDTH]};
      assign m_data   = sh[OUT_WIDTH-1:0];
    end
  endgenerate

  // Load a new beat on input fire (wins over the concurrent last-word drain),
  // otherwise advance one word per output fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh  <= '0;
      rem <= '0;
      lst <= 1'b0;
    end else if (in_fire) begin
      sh  <= s_data;
      rem <= eff_cnt;
      lst <= s_last;
    end else if (out_fire) begin
      sh  <= sh_drain;
      rem <= rem - ONE_CNT;
    end
  end

`ifdef STREAM_UNPACKER_STATS_EN
  // Free-running wrap-around counters of emitted words and completed streams.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_out    <= '0;
      streams_done <= '0;
    end else begin
      if (out_fire) begin
        words_out <= words_out + 32'd1;
      end
      if (out_fire && m_last) begin
        streams_done <= streams_done + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_unpacker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_stream_unpacker                                            |
// | Brief   : Table-driven bench for stream_unpacker. One LSB-first and one |
// |           MSB-first instance share all inputs; per-cycle vectors hold   |
// |           hand-computed outputs for both. Reset mid-beat is a separate  |
// |           hand-written sequence.                                        |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module tb_stream_unpacker;

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2 = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] D3 = 128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic [127:0] s_data;
  logic [2:0]   s_count;
  logic         s_last;
  logic         m_ready;

  logic         s_ready_l, m_valid_l, m_last_l;
  logic [31:0]  m_data_l;
  logic         s_ready_m, m_valid_m, m_last_m;
  logic [31:0]  m_data_m;
`ifdef STREAM_UNPACKER_STATS_EN
  logic [31:0]  words_out_l, words_out_m;
  logic [15:0]  streams_done_l, streams_done_m;
`endif

  always #5 clk = ~clk;

  stream_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(32), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready_l), .s_data(s_data), .s_count(s_count), .s_last(s_last),
    .m_valid(m_valid_l), .m_ready(m_ready), .m_data(m_data_l), .m_last(m_last_l)
`ifdef STREAM_UNPACKER_STATS_EN
    , .words_out(words_out_l), .streams_done(streams_done_l)
`endif
  );

  stream_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(32), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready_m), .s_data(s_data), .s_count(s_count), .s_last(s_last),
    .m_valid(m_valid_m), .m_ready(m_ready), .m_data(m_data_m), .m_last(m_last_m)
`ifdef STREAM_UNPACKER_STATS_EN
    , .words_out(words_out_m), .streams_done(streams_done_m)
`endif
  );

  typedef struct {
    logic         sv;
    logic [127:0] data;
    logic [2:0]   cnt;
    logic         last;
    logic         mr;
    logic         ev;   // expected m_valid
    logic [31:0]  d0;   // expected m_data, LSB-first instance
    logic [31:0]  d1;   // expected m_data, MSB-first instance
    logic         el;   // expected m_last
    logic         esr;  // expected s_ready
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ex_words   = 0;
  int   ex_streams = 0;

  function automatic void add(logic sv, logic [127:0] data, logic [2:0] cnt, logic last,
                              logic mr, logic ev, logic [31:0] d0, logic [31:0] d1,
                              logic el, logic esr);
    vec_t v;
    v.sv = sv; v.data = data; v.cnt = cnt; v.last = last; v.mr = mr;
    v.ev = ev; v.d0 = d0; v.d1 = d1; v.el = el; v.esr = esr;
    vecs.push_back(v);
  endfunction

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic drive(logic sv, logic [127:0] data, logic [2:0] cnt, logic last, logic mr);
    s_valid = sv; s_data = data; s_count = cnt; s_last = last; m_ready = mr;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 3'd0, 1'b0, 1'b0);

    // Single full beat, LSB order on dut_lsb and MSB order on dut_msb
    add(1, D1, 0, 0, 1,  0, 32'h0,        32'h0,        0, 1);
    add(0, 0,  0, 0, 1,  1, 32'h11111111, 32'h44444444, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'h22222222, 32'h33333333, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'h33333333, 32'h22222222, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'h44444444, 32'h11111111, 0, 1);
    add(0, 0,  0, 0, 1,  0, 32'h0,        32'h0,        0, 1);
    // Three back-to-back beats: 12 valid cycles without a gap
    add(1, D1, 0, 0, 1,  0, 32'h0,        32'h0,        0, 1);
    add(1, D2, 0, 0, 1,  1, 32'h11111111, 32'h44444444, 0, 0);
    add(1, D2, 0, 0, 1,  1, 32'h22222222, 32'h33333333, 0, 0);
    add(1, D2, 0, 0, 1,  1, 32'h33333333, 32'h22222222, 0, 0);
    add(1, D2, 0, 0, 1,  1, 32'h44444444, 32'h11111111, 0, 1);
    add(1, D3, 0, 0, 1,  1, 32'h55555555, 32'h88888888, 0, 0);
    add(1, D3, 0, 0, 1,  1, 32'h66666666, 32'h77777777, 0, 0);
    add(1, D3, 0, 0, 1,  1, 32'h77777777, 32'h66666666, 0, 0);
    add(1, D3, 0, 0, 1,  1, 32'h88888888, 32'h55555555, 0, 1);
    add(0, 0,  0, 0, 1,  1, 32'h99999999, 32'hCCCCCCCC, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'hBBBBBBBB, 32'hAAAAAAAA, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'hCCCCCCCC, 32'h99999999, 0, 1);
    add(0, 0,  0, 0, 1,  0, 32'h0,        32'h0,        0, 1);
    // Backpressure: m_ready 1,0,0,1,1,0,1 while the beat drains
    add(1, D1, 0, 0, 1,  0, 32'h0,        32'h0,        0, 1);
    add(0, 0,  0, 0, 1,  1, 32'h11111111, 32'h44444444, 0, 0);
    add(0, 0,  0, 0, 0,  1, 32'h22222222, 32'h33333333, 0, 0);
    add(0, 0,  0, 0, 0,  1, 32'h22222222, 32'h33333333, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'h22222222, 32'h33333333, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'h33333333, 32'h22222222, 0, 0);
    add(0, 0,  0, 0, 0,  1, 32'h44444444, 32'h11111111, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'h44444444, 32'h11111111, 0, 1);
    add(0, 0,  0, 0, 1,  0, 32'h0,        32'h0,        0, 1);
    // Partial last beat (2 words) followed by a full beat with no bubble
    add(1, D1, 2, 1, 1,  0, 32'h0,        32'h0,        0, 1);
    add(1, D2, 0, 0, 1,  1, 32'h11111111, 32'h44444444, 0, 0);
    add(1, D2, 0, 0, 1,  1, 32'h22222222, 32'h33333333, 1, 1);
    add(0, 0,  0, 0, 1,  1, 32'h55555555, 32'h88888888, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'h66666666, 32'h77777777, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'h77777777, 32'h66666666, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'h88888888, 32'h55555555, 0, 1);
    add(0, 0,  0, 0, 1,  0, 32'h0,        32'h0,        0, 1);
    // Single-word beat: only the first word of the chosen order appears
    add(1, D1, 1, 0, 1,  0, 32'h0,        32'h0,        0, 1);
    add(0, 0,  0, 0, 1,  1, 32'h11111111, 32'h44444444, 0, 1);
    add(0, 0,  0, 0, 1,  0, 32'h0,        32'h0,        0, 1);
    // Out-of-range count (7) clamps to a full beat; s_last marks the 4th word
    add(1, D3, 7, 1, 1,  0, 32'h0,        32'h0,        0, 1);
    add(0, 0,  0, 0, 1,  1, 32'h99999999, 32'hCCCCCCCC, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'hAAAAAAAA, 32'hBBBBBBBB, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'hBBBBBBBB, 32'hAAAAAAAA, 0, 0);
    add(0, 0,  0, 0, 1,  1, 32'hCCCCCCCC, 32'h99999999, 1, 1);
    add(0, 0,  0, 0, 1,  0, 32'h0,        32'h0,        0, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset m_valid", {127'd0, m_valid_l}, 128'd0);
    chk("reset m_last",  {127'd0, m_last_l},  128'd0);
    chk("reset m_data",  {96'd0, m_data_l},   128'd0);
    chk("reset s_ready", {127'd0, s_ready_l}, 128'd1);
    chk("reset msb m_data", {96'd0, m_data_m}, 128'd0);
`ifdef STREAM_UNPACKER_STATS_EN
    chk("reset words_out", {96'd0, words_out_l}, 128'd0);
`endif

    // Vector table, one cycle per entry
    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i].sv, vecs[i].data, vecs[i].cnt, vecs[i].last, vecs[i].mr);
      if (vecs[i].ev && vecs[i].mr) ex_words++;
      if (vecs[i].ev && vecs[i].el && vecs[i].mr) ex_streams++;
      @(negedge clk);
      chk($sformatf("v%0d m_valid", i),     {127'd0, m_valid_l}, {127'd0, vecs[i].ev});
      chk($sformatf("v%0d msb m_valid", i), {127'd0, m_valid_m}, {127'd0, vecs[i].ev});
      chk($sformatf("v%0d s_ready", i),     {127'd0, s_ready_l}, {127'd0, vecs[i].esr});
      chk($sformatf("v%0d msb s_ready", i), {127'd0, s_ready_m}, {127'd0, vecs[i].esr});
      chk($sformatf("v%0d m_last", i),      {127'd0, m_last_l},  {127'd0, vecs[i].el});
      chk($sformatf("v%0d msb m_last", i),  {127'd0, m_last_m},  {127'd0, vecs[i].el});
      if (vecs[i].ev) begin
        chk($sformatf("v%0d m_data", i),     {96'd0, m_data_l}, {96'd0, vecs[i].d0});
        chk($sformatf("v%0d msb m_data", i), {96'd0, m_data_m}, {96'd0, vecs[i].d1});
      end
    end

`ifdef STREAM_UNPACKER_STATS_EN
    chk("words_out",        {96'd0, words_out_l},    ex_words);
    chk("streams_done",     {112'd0, streams_done_l}, ex_streams);
    chk("msb streams_done", {112'd0, streams_done_m}, ex_streams);
`endif

    // Reset after the second word of a beat has fired
    @(posedge clk);
    #1 drive(1'b1, D1, 3'd0, 1'b1, 1'b1);
    @(posedge clk);
    #1 drive(1'b0, '0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst-mid word1", {96'd0, m_data_l}, 128'h11111111);
    @(negedge clk);
    chk("rst-mid word2", {96'd0, m_data_l}, 128'h22222222);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst-mid word3 before reset edge", {96'd0, m_data_l}, 128'h33333333);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst-mid m_valid", {127'd0, m_valid_l}, 128'd0);
    chk("rst-mid s_ready", {127'd0, s_ready_l}, 128'd1);
    chk("rst-mid m_last",  {127'd0, m_last_l},  128'd0);
    chk("rst-mid msb m_valid", {127'd0, m_valid_m}, 128'd0);
`ifdef STREAM_UNPACKER_STATS_EN
    chk("rst-mid words_out",    {96'd0, words_out_l},     128'd0);
    chk("rst-mid streams_done", {112'd0, streams_done_l}, 128'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst-mid idle%0d m_valid", k), {127'd0, m_valid_l}, 128'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
